// File: rtl/sample_mem_pkg.sv
// Shared types and helpers for the sample memory arbiter: FSM states,
// default widths and the round-robin winner search.
package sample_mem_pkg;

    localparam int unsigned SM_AW      = 25;
    localparam int unsigned SM_TIMEOUT = 255;
    localparam int unsigned MAX_CH     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_result_t;

    // First set request at or above base, wrapping at n; base is assumed < n.
    function automatic rr_result_t rr_winner(input logic [MAX_CH-1:0] req,
                                             input int unsigned       n,
                                             input logic [2:0]        base);
        rr_result_t  r;
        int unsigned k;
        r = '0;
        for (int unsigned off = 0; off < MAX_CH; off++) begin
            if (off < n) begin
                k = 32'(base) + off;
                if (k >= n) k = k - n;
                if (!r.valid && k < MAX_CH && req[k]) begin
                    r.valid = 1'b1;
                    r.idx   = k[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder over NUM_CH requesters with a
// rotating base pointer.
module rr_pick
    import sample_mem_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [2:0]        i_base,
    output logic              o_valid,
    output logic [2:0]        o_idx
);

    logic [MAX_CH-1:0] w_req_ext;
    rr_result_t        w_res;

    always_comb begin
        w_req_ext               = '0;
        w_req_ext[NUM_CH-1:0]   = i_req;
        w_res                   = rr_winner(w_req_ext, NUM_CH, i_base);
    end

    assign o_valid = w_res.valid;
    assign o_idx   = w_res.idx;

endmodule

// File: rtl/sample_mem_arbiter.sv
// Sequences the shared SDRAM port between ioctl download writes (absolute
// priority, one-entry buffer) and round-robin sample-voice word reads.
module sample_mem_arbiter
    import sample_mem_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned AW      = SM_AW,
    parameter int unsigned TIMEOUT = SM_TIMEOUT
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_dl_active,
    input  logic                 i_dl_wr,
    input  logic [AW-1:0]        i_dl_addr,
    input  logic [7:0]           i_dl_data,
    output logic                 o_dl_wait,
    input  logic [NUM_CH-1:0]    i_ch_req,
    input  logic [NUM_CH*AW-1:0] i_ch_addr,
    output logic [NUM_CH-1:0]    o_ch_ack,
    output logic [15:0]          o_ch_data,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [AW-1:0]        o_mem_addr,
    output logic [7:0]           o_mem_din,
    input  logic                 i_mem_ack,
    input  logic [15:0]          i_mem_dout,
    output logic                 o_err_timeout,
    output logic                 o_err_overflow
);

    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
    localparam logic [7:0] TO_LIM  = 8'(TIMEOUT);

    state_t              r_state;
    logic                r_buf_full;
    logic [AW-1:0]       r_buf_addr;
    logic [7:0]          r_buf_data;
    logic                r_is_write;
    logic [2:0]          r_grant;
    logic [2:0]          r_ptr;
    logic [7:0]          r_cnt;
    logic                r_dl_wait;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [AW-1:0]       r_mem_addr;
    logic [7:0]          r_mem_din;
    logic [NUM_CH-1:0]   r_ch_ack;
    logic [15:0]         r_ch_data;
    logic                r_err_to;
    logic                r_err_ov;

    logic                w_pick_valid;
    logic [2:0]          w_pick_idx;
    logic [AW-1:0]       w_rd_slice;
    logic [AW-1:0]       w_rd_addr;
    logic [NUM_CH-1:0]   w_grant_oh;
    logic                w_dl_wr;
    logic                w_drain;
    logic                w_accept;
    logic                w_overflow;
    logic                w_buf_full_nxt;
    logic [7:0]          w_cnt_inc;
    logic                w_timeout;
    logic [2:0]          w_ptr_adv;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .i_req   (i_ch_req),
        .i_base  (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_rd_slice = '0;
        w_grant_oh = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_pick_idx == 3'(i)) w_rd_slice = i_ch_addr[i*AW +: AW];
            w_grant_oh[i] = (r_grant == 3'(i));
        end
    end

    assign w_rd_addr      = w_rd_slice & ~{{(AW-1){1'b0}}, 1'b1};
    assign w_dl_wr        = i_dl_wr && i_dl_active;
    assign w_drain        = (r_state == ST_WAIT) && i_mem_ack && r_is_write;
    assign w_accept       = w_dl_wr && (!r_buf_full || w_drain);
    assign w_overflow     = w_dl_wr && r_buf_full && !w_drain;
    assign w_buf_full_nxt = w_accept ? 1'b1 : (w_drain ? 1'b0 : r_buf_full);
    assign w_cnt_inc      = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_timeout      = (r_state == ST_WAIT) && !i_mem_ack && (w_cnt_inc == TO_LIM);
    assign w_ptr_adv      = (r_grant == LAST_CH) ? 3'd0 : r_grant + 3'd1;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_buf_full <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_is_write <= 1'b0;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_dl_wait  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_ch_ack   <= '0;
            r_ch_data  <= '0;
            r_err_to   <= 1'b0;
            r_err_ov   <= 1'b0;
        end else begin
            r_mem_req  <= 1'b0;
            r_ch_ack   <= '0;
            r_buf_full <= w_buf_full_nxt;
            // Rises with the fill, falls one cycle after the drain.
            r_dl_wait  <= w_buf_full_nxt | r_buf_full;
            if (w_accept) begin
                r_buf_addr <= i_dl_addr;
                r_buf_data <= i_dl_data;
            end
            if (w_overflow) r_err_ov <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (r_buf_full) begin
                        r_is_write <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_buf_addr;
                        r_mem_din  <= r_buf_data;
                        r_state    <= ST_ISSUE;
                    end else if (!i_dl_active && w_pick_valid) begin
                        r_is_write <= 1'b0;
                        r_grant    <= w_pick_idx;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_rd_addr;
                        r_mem_din  <= '0;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mem_ack) begin
                        if (!r_is_write) begin
                            r_ch_data <= i_mem_dout;
                            r_ch_ack  <= w_grant_oh;
                            r_ptr     <= w_ptr_adv;
                        end
                        r_state <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_err_to <= 1'b1;
                        if (!r_is_write) r_ptr <= w_ptr_adv;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_dl_wait      = r_dl_wait;
    assign o_ch_ack       = r_ch_ack;
    assign o_ch_data      = r_ch_data;
    assign o_mem_req      = r_mem_req;
    assign o_mem_we       = r_mem_we;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_din      = r_mem_din;
    assign o_err_timeout  = r_err_to;
    assign o_err_overflow = r_err_ov;

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// Directed self-checking bench for sample_mem_arbiter.
module tb_sample_mem_arbiter;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          dl_active;
    logic          dl_wr;
    logic [24:0]   dl_addr;
    logic [7:0]    dl_data;
    logic          dl_wait;
    logic [3:0]    ch_req;
    logic [99:0]   ch_addr;
    logic [3:0]    ch_ack;
    logic [15:0]   ch_data;
    logic          mem_req;
    logic          mem_we;
    logic [24:0]   mem_addr;
    logic [7:0]    mem_din;
    logic          mem_ack;
    logic [15:0]   mem_dout;
    logic          err_timeout;
    logic          err_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_mem_arbiter #(.NUM_CH(4), .AW(25), .TIMEOUT(255)) dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_dl_active    (dl_active),
        .i_dl_wr        (dl_wr),
        .i_dl_addr      (dl_addr),
        .i_dl_data      (dl_data),
        .o_dl_wait      (dl_wait),
        .i_ch_req       (ch_req),
        .i_ch_addr      (ch_addr),
        .o_ch_ack       (ch_ack),
        .o_ch_data      (ch_data),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_din      (mem_din),
        .i_mem_ack      (mem_ack),
        .i_mem_dout     (mem_dout),
        .o_err_timeout  (err_timeout),
        .o_err_overflow (err_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_mem_req(input string tag);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"},  32'(mem_req),      32'd0);
        chk({tag, "_mem_we"},   32'(mem_we),       32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr),     32'd0);
        chk({tag, "_mem_din"},  32'(mem_din),      32'd0);
        chk({tag, "_dl_wait"},  32'(dl_wait),      32'd0);
        chk({tag, "_ch_ack"},   32'(ch_ack),       32'd0);
        chk({tag, "_ch_data"},  32'(ch_data),      32'd0);
        chk({tag, "_err_to"},   32'(err_timeout),  32'd0);
        chk({tag, "_err_ov"},   32'(err_overflow), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          exp_v [3];
        logic [24:0] exp_a [3];
        int          nreq;
        logic        ack_seen;
        logic        req_seen;

        exp_v = '{0, 1, 3};
        exp_a = '{25'h100, 25'h200, 25'h400};

        reset_n   = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        ch_req    = '0;
        ch_addr   = '0;
        mem_ack   = 1'b0;
        mem_dout  = '0;
        tick();
        tick();
        chk_all_zero("rst");
        reset_n = 1'b1;
        tick();

        // Single download byte: dl_wr at cycle 0, mem_ack at cycle 5.
        dl_active = 1'b1;
        dl_wr     = 1'b1;
        dl_addr   = 25'h10;
        dl_data   = 8'hA5;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) dl_wr = 1'b0;
            if (c == 5) mem_ack = 1'b1;
            if (c == 6) mem_ack = 1'b0;
            chk($sformatf("dl_wait_c%0d", c), 32'(dl_wait), (c <= 6) ? 32'd1 : 32'd0);
            chk($sformatf("dl_req_c%0d", c),  32'(mem_req), (c == 2) ? 32'd1 : 32'd0);
            if (c == 2) begin
                chk("dl_we",   32'(mem_we),   32'd1);
                chk("dl_addr", 32'(mem_addr), 32'h10);
                chk("dl_din",  32'(mem_din),  32'hA5);
            end
        end
        dl_active = 1'b0;

        // Round-robin over voices 0,1,3; voice 1 address gets word aligned.
        ch_addr[0*25 +: 25] = 25'h100;
        ch_addr[1*25 +: 25] = 25'h201;
        ch_addr[2*25 +: 25] = 25'h300;
        ch_addr[3*25 +: 25] = 25'h400;
        ch_req = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            wait_mem_req($sformatf("rr_req%0d", k));
            chk($sformatf("rr_we%0d", k),   32'(mem_we),   32'd0);
            chk($sformatf("rr_addr%0d", k), 32'(mem_addr), 32'(exp_a[k]));
            tick();
            tick();
            tick();
            chk($sformatf("rr_early_ack%0d", k), 32'(ch_ack), 32'd0);
            mem_ack  = 1'b1;
            mem_dout = 16'h1234 + 16'(k);
            tick();
            mem_ack = 1'b0;
            chk($sformatf("rr_ack%0d", k),  32'(ch_ack),  32'd1 << exp_v[k]);
            chk($sformatf("rr_data%0d", k), 32'(ch_data), 32'h1234 + 32'(k));
            ch_req[exp_v[k]] = 1'b0;
            tick();
            chk($sformatf("rr_ack_pulse%0d", k), 32'(ch_ack),  32'd0);
            chk($sformatf("rr_hold%0d", k),      32'(ch_data), 32'h1234 + 32'(k));
        end

        // Priority: buffered write and voice 2 pending in the same IDLE cycle.
        dl_active = 1'b1;
        dl_wr     = 1'b1;
        dl_addr   = 25'h55;
        dl_data   = 8'h3C;
        tick();
        dl_wr     = 1'b0;
        dl_active = 1'b0;
        ch_req    = 4'b0100;
        tick();
        chk("pri_req",  32'(mem_req),  32'd1);
        chk("pri_we",   32'(mem_we),   32'd1);
        chk("pri_addr", 32'(mem_addr), 32'h55);
        chk("pri_din",  32'(mem_din),  32'h3C);
        tick();
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("pri_wr_noack", 32'(ch_ack), 32'd0);
        wait_mem_req("pri_rd_req");
        chk("pri_rd_we",   32'(mem_we),   32'd0);
        chk("pri_rd_addr", 32'(mem_addr), 32'h300);
        tick();
        mem_ack  = 1'b1;
        mem_dout = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        chk("pri_rd_ack",  32'(ch_ack),       32'b0100);
        chk("pri_rd_data", 32'(ch_data),      32'hBEEF);
        chk("pri_no_ovf",  32'(err_overflow), 32'd0);
        ch_req = '0;
        tick();

        // Overflow: two back-to-back bytes, only the first reaches memory.
        dl_active = 1'b1;
        dl_wr     = 1'b1;
        dl_addr   = 25'h77;
        dl_data   = 8'h11;
        tick();
        dl_addr = 25'h78;
        dl_data = 8'h22;
        tick();
        dl_wr = 1'b0;
        chk("ovf_flag", 32'(err_overflow), 32'd1);
        chk("ovf_req",  32'(mem_req),      32'd1);
        chk("ovf_addr", 32'(mem_addr),     32'h77);
        chk("ovf_din",  32'(mem_din),      32'h11);
        nreq = 1;
        for (int c = 3; c <= 12; c++) begin
            tick();
            if (c == 6) mem_ack = 1'b1;
            if (c == 7) mem_ack = 1'b0;
            if (mem_req === 1'b1) nreq++;
        end
        chk("ovf_nwrites", 32'(nreq),    32'd1);
        chk("ovf_wait",    32'(dl_wait), 32'd0);
        dl_active = 1'b0;

        // Timeout on voice 0 read; pointer must then move on to voice 1.
        ch_req = 4'b0011;
        wait_mem_req("to_req");
        chk("to_addr", 32'(mem_addr), 32'h100);
        ack_seen = 1'b0;
        req_seen = 1'b0;
        for (int c = 1; c <= 255; c++) begin
            tick();
            if (ch_ack !== 4'b0000) ack_seen = 1'b1;
            if (mem_req !== 1'b0) req_seen = 1'b1;
        end
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        tick();
        chk("to_flag",    32'(err_timeout), 32'd1);
        chk("to_no_ack",  32'(ack_seen),    32'd0);
        chk("to_no_req",  32'(req_seen),    32'd0);
        tick();
        chk("to_next_req",  32'(mem_req),  32'd1);
        chk("to_next_addr", 32'(mem_addr), 32'h200);

        // Reset during WAIT, then a stray mem_ack.
        tick();
        reset_n = 1'b0;
        ch_req  = '0;
        tick();
        reset_n  = 1'b1;
        mem_ack  = 1'b1;
        mem_dout = 16'hDEAD;
        chk_all_zero("rstw");
        tick();
        mem_ack = 1'b0;
        chk("stray_ack",  32'(ch_ack),  32'd0);
        chk("stray_data", 32'(ch_data), 32'd0);
        chk("stray_req",  32'(mem_req), 32'd0);
        tick();
        chk("stray_ack2", 32'(ch_ack),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
